// File: rtl/spi_encoder_read_ctrl.sv
// Sequences SPI reads of the encoder snapshot memory: oversamples cs/sck in the clk
// domain, decodes the command byte and drives freeze, byte address and shifter load.
module spi_encoder_read_ctrl #(
    parameter int NUM_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sck,
    input  logic [7:0] spiDataIn,
    output logic       freezeData,
    output logic [7:0] addressOut,
    output logic       setNewData,
    output logic       busy,
    output logic       frameErr,
    output logic [7:0] byteCount
);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        CMD,
        DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] DEPTH     = 8'(NUM_BYTES);
    localparam logic [7:0] LAST_ADDR = 8'(NUM_BYTES - 1);

    // Bit 1 = cs, bit 0 = sck
    logic [1:0] pin_raw;
    logic [1:0] sync_meta_reg;
    logic [1:0] sync_reg;
    logic       sck_d_reg;
    logic [1:0] primed_reg;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] byte_count_reg, byte_count_next;
    logic [7:0] addr_reg, addr_next;
    logic       freeze_reg, freeze_next;
    logic       frame_err_reg, frame_err_next;
    logic       load_pending_reg, load_pending_next;
    logic       set_new_data_reg;

    logic cs_s;
    logic sck_s;
    logic sck_rise;
    logic byte_done;

    assign pin_raw = {cs, sck};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_meta_reg[gi] <= 1'b1;
                    sync_reg[gi]      <= 1'b1;
                end else begin
                    sync_meta_reg[gi] <= pin_raw[gi];
                    sync_reg[gi]      <= sync_meta_reg[gi];
                end
            end
        end
    endgenerate

    assign cs_s      = sync_reg[1];
    assign sck_s     = sync_reg[0];
    assign sck_rise  = sck_s & ~sck_d_reg;
    assign byte_done = sck_rise && (bit_cnt_reg == 3'd7);

    // The synchronizers restart at 1 after reset, so cs_s only reflects the real pin
    // once both stages have refilled; until then WAIT_IDLE must not trust it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_d_reg  <= 1'b1;
            primed_reg <= 2'b00;
        end else begin
            sck_d_reg  <= sck_s;
            primed_reg <= {primed_reg[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= WAIT_IDLE;
            bit_cnt_reg      <= 3'd0;
            byte_count_reg   <= 8'd0;
            addr_reg         <= 8'd0;
            freeze_reg       <= 1'b0;
            frame_err_reg    <= 1'b0;
            load_pending_reg <= 1'b0;
            set_new_data_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            byte_count_reg   <= byte_count_next;
            addr_reg         <= addr_next;
            freeze_reg       <= freeze_next;
            frame_err_reg    <= frame_err_next;
            load_pending_reg <= load_pending_next;
            set_new_data_reg <= load_pending_reg;
        end
    end

    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        byte_count_next   = byte_count_reg;
        addr_next         = addr_reg;
        freeze_next       = freeze_reg;
        frame_err_next    = frame_err_reg;
        load_pending_next = 1'b0;

        unique case (state_reg)
            WAIT_IDLE: begin
                if (primed_reg[1] && cs_s) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!cs_s) begin
                    state_next     = CMD;
                    bit_cnt_next   = 3'd0;
                    byte_count_next = 8'd0;
                    frame_err_next = 1'b0;
                    freeze_next    = 1'b1;
                end
            end
            CMD, DATA, IGNORE: begin
                // Frame end takes priority over a byte completing in the same cycle
                if (cs_s) begin
                    state_next  = IDLE;
                    freeze_next = 1'b0;
                    if (bit_cnt_reg != 3'd0) begin
                        frame_err_next = 1'b1;
                    end
                end else if (sck_rise) begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (byte_done) begin
                        if (byte_count_reg != 8'hFF) begin
                            byte_count_next = byte_count_reg + 8'd1;
                        end
                        if (state_reg == CMD) begin
                            if (spiDataIn[7] && ({1'b0, spiDataIn[6:0]} < DEPTH)) begin
                                addr_next         = {1'b0, spiDataIn[6:0]};
                                load_pending_next = 1'b1;
                                state_next        = DATA;
                            end else begin
                                state_next = IGNORE;
                            end
                        end else if (state_reg == DATA) begin
                            addr_next         = (addr_reg == LAST_ADDR) ? 8'd0 : addr_reg + 8'd1;
                            load_pending_next = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = WAIT_IDLE;
            end
        endcase
    end

    assign freezeData = freeze_reg;
    assign addressOut = addr_reg;
    assign setNewData = set_new_data_reg;
    assign busy       = (state_reg == CMD) || (state_reg == DATA) || (state_reg == IGNORE);
    assign frameErr   = frame_err_reg;
    assign byteCount  = byte_count_reg;

endmodule

// File: tb/tb_spi_encoder_read_ctrl.sv
// Directed bench for spi_encoder_read_ctrl: drives SPI frames on cs/sck and checks
// addresses, load pulses, byte counts, freeze latency and frame errors.
module tb_spi_encoder_read_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1;
    logic       sck = 1'b0;
    logic [7:0] spi_data_in = 8'h00;
    logic       freeze_data;
    logic [7:0] address_out;
    logic       set_new_data;
    logic       busy;
    logic       frame_err;
    logic [7:0] byte_count;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulse_base;
    logic [7:0] addr_q[$];
    logic snd_prev = 1'b0;

    spi_encoder_read_ctrl #(.NUM_BYTES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .sck        (sck),
        .spiDataIn  (spi_data_in),
        .freezeData (freeze_data),
        .addressOut (address_out),
        .setNewData (set_new_data),
        .busy       (busy),
        .frameErr   (frame_err),
        .byteCount  (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    always @(negedge clk) begin
        if (set_new_data) begin
            chk("snd_single", {31'd0, snd_prev}, 32'd0);
            pulse_cnt++;
            addr_q.push_back(address_out);
        end
        snd_prev = set_new_data;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        spi_data_in = b;
        for (int i = 0; i < n; i++) begin
            sck = 1'b0;
            wait_clk(8);
            sck = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic start_frame(input string tag);
        @(negedge clk);
        sck = 1'b0;
        cs  = 1'b0;
        wait_clk(2);
        chk({tag, "_frz_pre"}, {31'd0, freeze_data}, 32'd0);
        wait_clk(1);
        chk({tag, "_frz_on"}, {31'd0, freeze_data}, 32'd1);
        chk({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
        pulse_base = pulse_cnt;
        addr_q.delete();
    endtask

    task automatic end_frame(input string tag);
        sck = 1'b0;
        wait_clk(4);
        cs = 1'b1;
        wait_clk(2);
        chk({tag, "_frz_hold"}, {31'd0, freeze_data}, 32'd1);
        wait_clk(1);
        chk({tag, "_frz_off"}, {31'd0, freeze_data}, 32'd0);
        chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        wait_clk(4);
    endtask

    task automatic chk_addrs(input string tag, input logic [39:0] exp, input int n);
        chk({tag, "_pulses"}, pulse_cnt - pulse_base, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i),
                (i < addr_q.size()) ? {24'd0, addr_q[i]} : 32'hFFFF, {24'd0, exp[8*i +: 8]});
        end
    endtask

    initial begin
        // Reset values
        wait_clk(3);
        chk("rst_freeze", {31'd0, freeze_data}, 32'd0);
        chk("rst_addr", {24'd0, address_out}, 32'd0);
        chk("rst_snd", {31'd0, set_new_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_bcnt", {24'd0, byte_count}, 32'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // 0x82 + 3 data bytes: addresses 2,3,4,5
        start_frame("t1");
        send_byte(8'h82);
        repeat (3) send_byte(8'h00);
        chk("t1_bcnt", {24'd0, byte_count}, 32'd4);
        end_frame("t1");
        chk_addrs("t1", {8'd0, 8'd5, 8'd4, 8'd3, 8'd2}, 4);

        // 0x86 + 4 data bytes with wrap: 6,7,0,1,2
        start_frame("t2");
        send_byte(8'h86);
        repeat (4) send_byte(8'h00);
        chk("t2_bcnt", {24'd0, byte_count}, 32'd5);
        end_frame("t2");
        chk_addrs("t2", {8'd2, 8'd1, 8'd0, 8'd7, 8'd6}, 5);

        // Read bit clear, then out-of-range address: both ignored
        start_frame("t3a");
        send_byte(8'h05);
        repeat (2) send_byte(8'h83);
        chk("t3a_bcnt", {24'd0, byte_count}, 32'd3);
        end_frame("t3a");
        chk("t3a_pulses", pulse_cnt - pulse_base, 0);
        chk("t3a_addr", {24'd0, address_out}, 32'd2);
        start_frame("t3b");
        send_byte(8'h88);
        repeat (2) send_byte(8'h81);
        chk("t3b_bcnt", {24'd0, byte_count}, 32'd3);
        end_frame("t3b");
        chk("t3b_pulses", pulse_cnt - pulse_base, 0);
        chk("t3b_addr", {24'd0, address_out}, 32'd2);

        // 0x80 then cs rises after 5 bits: frame error
        start_frame("t4");
        send_byte(8'h80);
        send_bits(8'h00, 5);
        end_frame("t4");
        chk("t4_ferr", {31'd0, frame_err}, 32'd1);
        chk_addrs("t4", {32'd0, 8'd0}, 1);
        start_frame("t4c");
        chk("t4c_ferr_clr", {31'd0, frame_err}, 32'd0);
        send_byte(8'h07);
        end_frame("t4c");
        chk("t4c_ferr", {31'd0, frame_err}, 32'd0);

        // Reset mid byte 2 with cs held low
        start_frame("t5");
        send_byte(8'h82);
        send_bits(8'h00, 3);
        rst_n = 1'b0;
        wait_clk(2);
        chk("t5_rst_freeze", {31'd0, freeze_data}, 32'd0);
        chk("t5_rst_addr", {24'd0, address_out}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_bcnt", {24'd0, byte_count}, 32'd0);
        rst_n = 1'b1;
        pulse_base = pulse_cnt;
        send_bits(8'h82, 5);
        send_byte(8'h82);
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        chk("t5_no_pulse", pulse_cnt - pulse_base, 0);
        sck = 1'b0;
        wait_clk(4);
        cs = 1'b1;
        wait_clk(8);
        start_frame("t5n");
        send_byte(8'h81);
        end_frame("t5n");
        chk_addrs("t5n", {32'd0, 8'd1}, 1);

        // cs rise coincident with the 8th sck rise of byte 2
        start_frame("t6");
        send_byte(8'h81);
        send_bits(8'h00, 7);
        sck = 1'b0;
        wait_clk(8);
        sck = 1'b1;
        cs  = 1'b1;
        wait_clk(10);
        chk("t6_pulses", pulse_cnt - pulse_base, 1);
        chk("t6_bcnt", {24'd0, byte_count}, 32'd1);
        chk("t6_addr", {24'd0, address_out}, 32'd1);
        chk("t6_ferr", {31'd0, frame_err}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        sck = 1'b0;
        wait_clk(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
